regfile_wb_scheduler: RTL and testbench

Write-back scheduler and hazard scoreboard for the 32x64 register file.
- Arbitrates the register file's single write port between the ALU result path and the load (memory) result path.
- Tracks registers with in-flight writes so the issue stage stalls on RAW/WAW hazards.
- Sits between the execute/memory stages and the register file. It drives rd, writedata and reg_write of the register file directly.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 29 ++
 rtl/regfile_wb_scheduler.sv | 87 ++++++++
 tb/tb_regfile_wb_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizing for the register-file write-back scheduler.
package regfile_pkg;

   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int AW   = $clog2(NREG);

   typedef enum logic {WB_ALU = 1'b0, WB_MEM = 1'b1} wb_src_e;

   typedef struct packed {
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; grant[0]=ALU, grant[1]=MEM, one-hot or zero.
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   wb_src_e last_grant;

   always_comb begin
      grant = req;
      // On a tie the source that did not win last time goes first.
      if (req == 2'b11)
         grant = (last_grant == WB_MEM) ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk) begin
      if (reset)
         last_grant <= WB_MEM;
      else if (grant[0])
         last_grant <= WB_ALU;
      else if (grant[1])
         last_grant <= WB_MEM;
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-port arbiter between ALU and load results, plus the RAW/WAW hazard
// scoreboard that stalls issue while a destination write is outstanding.
module regfile_wb_scheduler
   import regfile_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic [AW-1:0]   issue_rs1,
   input  logic [AW-1:0]   issue_rs2,
   output logic            issue_stall,
   input  logic            alu_valid,
   input  logic [AW-1:0]   alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            mem_valid,
   input  logic [AW-1:0]   mem_rd,
   input  logic [XLEN-1:0] mem_data,
   output logic            mem_ready,
   output logic [AW-1:0]   rf_rd,
   output logic [XLEN-1:0] rf_writedata,
   output logic            rf_reg_write,
   output logic [NREG-1:0] pending,
   output logic            wb_unexpected
);

   logic [1:0]      grant;
   logic            accept;
   logic            fire;
   logic            win_nz;
   wb_req_t         alu_req;
   wb_req_t         mem_req;
   wb_req_t         win;
   logic [NREG-1:0] pending_nxt;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   ({mem_valid, alu_valid}),
      .grant (grant)
   );

   assign alu_ready = grant[0];
   assign mem_ready = grant[1];
   assign accept    = |grant;
   assign alu_req   = '{rd: alu_rd, data: alu_data};
   assign mem_req   = '{rd: mem_rd, data: mem_data};
   assign win       = grant[1] ? mem_req : alu_req;
   assign win_nz    = (win.rd != '0);

   assign issue_stall = issue_valid &
                        (((issue_rs1 != '0) & pending[issue_rs1]) |
                         ((issue_rs2 != '0) & pending[issue_rs2]) |
                         ((issue_rd  != '0) & pending[issue_rd]));
   assign fire = issue_valid & ~issue_stall;

   // Clear lands after the register file commits; a same-cycle set is a new producer and wins.
   always_comb begin
      pending_nxt = pending;
      if (rf_reg_write)
         pending_nxt[rf_rd] = 1'b0;
      if (fire && issue_rd != '0)
         pending_nxt[issue_rd] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rf_rd         <= '0;
         rf_writedata  <= '0;
         rf_reg_write  <= 1'b0;
         pending       <= '0;
         wb_unexpected <= 1'b0;
      end else begin
         rf_reg_write <= accept & win_nz;
         if (accept && win_nz) begin
            rf_rd        <= win.rd;
            rf_writedata <= win.data;
         end
         pending <= pending_nxt;
         if (accept && win_nz && !pending[win.rd])
            wb_unexpected <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with a reference model and write-back scoreboard.
module tb_regfile_wb_scheduler;
   import regfile_pkg::*;

   logic            clk = 1'b0;
   logic            reset;
   logic            issue_valid;
   logic [AW-1:0]   issue_rd, issue_rs1, issue_rs2;
   logic            issue_stall;
   logic            alu_valid;
   logic [AW-1:0]   alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            alu_ready;
   logic            mem_valid;
   logic [AW-1:0]   mem_rd;
   logic [XLEN-1:0] mem_data;
   logic            mem_ready;
   logic [AW-1:0]   rf_rd;
   logic [XLEN-1:0] rf_writedata;
   logic            rf_reg_write;
   logic [NREG-1:0] pending;
   logic            wb_unexpected;

   always #5 clk = ~clk;

   regfile_wb_scheduler dut (
      .clk           (clk),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_rd      (issue_rd),
      .issue_rs1     (issue_rs1),
      .issue_rs2     (issue_rs2),
      .issue_stall   (issue_stall),
      .alu_valid     (alu_valid),
      .alu_rd        (alu_rd),
      .alu_data      (alu_data),
      .alu_ready     (alu_ready),
      .mem_valid     (mem_valid),
      .mem_rd        (mem_rd),
      .mem_data      (mem_data),
      .mem_ready     (mem_ready),
      .rf_rd         (rf_rd),
      .rf_writedata  (rf_writedata),
      .rf_reg_write  (rf_reg_write),
      .pending       (pending),
      .wb_unexpected (wb_unexpected)
   );

   int n_pass  = 0;
   int n_total = 0;

   logic            m_last_mem;
   logic [NREG-1:0] m_pending;
   logic            m_unexp;
   logic            m_rfw;
   logic [AW-1:0]   m_rfrd;
   logic [XLEN-1:0] m_rfdata;
   wb_req_t         q[$];

   logic s_stall, s_aready, s_mready;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic idle();
      issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_last_mem = 1'b1; m_pending = '0; m_unexp = 1'b0;
      m_rfw = 1'b0; m_rfrd = '0; m_rfdata = '0;
      q.delete();
      chk("rst_wr",   rf_reg_write,  0);
      chk("rst_rd",   rf_rd,         0);
      chk("rst_data", rf_writedata,  0);
      chk("rst_pend", pending,       0);
      chk("rst_unex", wb_unexpected, 0);
   endtask

   // One clock: check combinational outputs mid-cycle, advance the model, check registered outputs.
   task automatic step();
      logic    ga, gm, stall_e, nw;
      wb_req_t w;
      @(negedge clk);
      s_stall = issue_stall; s_aready = alu_ready; s_mready = mem_ready;
      stall_e = issue_valid & (((issue_rs1 != 0) & m_pending[issue_rs1]) |
                               ((issue_rs2 != 0) & m_pending[issue_rs2]) |
                               ((issue_rd  != 0) & m_pending[issue_rd]));
      ga = alu_valid & (~mem_valid | m_last_mem);
      gm = mem_valid & (~alu_valid | ~m_last_mem);
      chk("alu_ready", alu_ready, ga);
      chk("mem_ready", mem_ready, gm);
      chk("stall", issue_stall, stall_e);
      w  = ga ? '{rd: alu_rd, data: alu_data} : '{rd: mem_rd, data: mem_data};
      nw = (ga | gm) && (w.rd != 0);
      if (nw && !m_pending[w.rd]) m_unexp = 1'b1;
      if (ga) m_last_mem = 1'b0;
      else if (gm) m_last_mem = 1'b1;
      if (m_rfw) m_pending[m_rfrd] = 1'b0;
      if (issue_valid && !stall_e && issue_rd != 0) m_pending[issue_rd] = 1'b1;
      if (nw) q.push_back(w);
      @(posedge clk); #1;
      m_rfw = nw;
      chk("rf_reg_write", rf_reg_write, nw);
      if (nw) begin
         w = q.pop_front();
         m_rfrd = w.rd; m_rfdata = w.data;
      end
      chk("rf_rd", rf_rd, m_rfrd);
      chk("rf_writedata", rf_writedata, m_rfdata);
      chk("pending", pending, m_pending);
      chk("wb_unexpected", wb_unexpected, m_unexp);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      do_reset();

      // Round-robin on four consecutive ties, ALU first after reset.
      issue_valid = 1'b1; issue_rd = 5'd1; step();
      issue_rd = 5'd2; step();
      idle();
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h100;
      mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'h200;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t2_grant_alu", s_aready, (i % 2 == 0) ? 1 : 0);
         chk("t2_rd", rf_rd, (i % 2 == 0) ? 1 : 2);
         if (i % 2 == 0) alu_data = alu_data + 1;
         else            mem_data = mem_data + 1;
      end
      idle(); step();
      chk("t2_idle_wr", rf_reg_write, 0);
      chk("t2_queue_empty", q.size(), 0);

      // ALU-only write to a pending register.
      do_reset();
      issue_valid = 1'b1; issue_rd = 5'd5; step();
      idle();
      chk("t1_p5_set", pending[5], 1);
      step();
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD; step();
      chk("t1_ready", s_aready, 1);
      idle();
      chk("t1_wr", rf_reg_write, 1);
      chk("t1_rd", rf_rd, 5);
      chk("t1_data", rf_writedata, 64'hDEAD);
      chk("t1_p5_still", pending[5], 1);
      step();
      chk("t1_p5_clr", pending[5], 0);
      chk("t1_unex", wb_unexpected, 0);

      // RAW stall until the cycle after the write of x7 commits.
      issue_valid = 1'b1; issue_rd = 5'd7; step();
      issue_rd = 5'd8; issue_rs1 = 5'd7;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
      step();
      chk("t3_stall_acc", s_stall, 1);
      alu_valid = 1'b0;
      step();
      chk("t3_stall_wr", s_stall, 1);
      step();
      chk("t3_unstall", s_stall, 0);
      chk("t3_p8", pending[8], 1);
      issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0; step();
      chk("t3_zero_nostall", s_stall, 0);
      idle();

      // x0 write is consumed silently; unexpected write sets the sticky error.
      mem_valid = 1'b1; mem_rd = '0; mem_data = 64'h55; step();
      chk("t5_mready", s_mready, 1);
      chk("t5_no_wr", rf_reg_write, 0);
      idle();
      alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'hC; step();
      idle();
      chk("t5_wr", rf_reg_write, 1);
      chk("t5_rd", rf_rd, 12);
      chk("t5_unex", wb_unexpected, 1);
      step(); step();
      chk("t5_sticky", wb_unexpected, 1);

      // Set/clear collision on x9: the new producer keeps the bit.
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99; step();
      idle();
      issue_valid = 1'b1; issue_rd = 5'd9; step();
      chk("t4_p9_kept", pending[9], 1);
      idle(); step();
      chk("t4_p9_hold", pending[9], 1);

      // Reset while a write is in flight, then the first tie goes to ALU.
      issue_valid = 1'b1; issue_rd = 5'd3; step();
      idle();
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33; step();
      chk("t6_pre_wr", rf_reg_write, 1);
      do_reset();
      alu_valid = 1'b1; alu_rd = '0; mem_valid = 1'b1; mem_rd = '0; step();
      chk("t6_tie_alu", s_aready, 1);
      chk("t6_tie_mem", s_mready, 0);
      idle(); step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
